// File: rtl/bus_master_port.sv
// bus_master_port
// Master-side endpoint for a shared bus arbitrated per master. Local words are
// buffered in a circular FIFO; while data waits the port requests the bus, and
// on grant it streams up to MAX_BURST words, then pulses a one-cycle release
// (ack) so the arbiter can re-arbitrate.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   i_wr_valid    in   local producer presents i_wr_data
//   i_wr_data     in   word to enqueue
//   o_wr_ready    out  FIFO can accept a word this cycle
//   i_bus_grant   in   this master's grant bit from the arbiter
//   i_bus_wait    in   target stall; current beat not consumed
//   o_bus_req     out  request to the arbiter (REQ and XFER)
//   o_bus_ack     out  one-cycle tenure release (REL)
//   o_bus_valid   out  o_bus_data carries a valid beat (XFER)
//   o_bus_data    out  FIFO head while o_bus_valid, else zero
//   o_err         out  sticky; grant lost mid-burst
module bus_master_port #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_bus_grant,
    input  logic              i_bus_wait,
    output logic              o_bus_req,
    output logic              o_bus_ack,
    output logic              o_bus_valid,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beats;
    logic              r_err;

    logic [1:0]        w_state_nxt;
    logic [BEAT_W-1:0] w_beats_nxt;
    logic [BEAT_W-1:0] w_burst_len;
    logic              w_err_set;
    logic              w_bus_valid;
    logic              w_push;
    logic              w_pop;

    // Moore output decode and FIFO handshake terms.
    always_comb begin
        w_bus_valid = (r_state == XFER);
        // A beat is consumed only while the grant is still held; on grant loss
        // the presented word stays in the FIFO for the next tenure.
        w_pop       = w_bus_valid && i_bus_grant && !i_bus_wait;
        o_wr_ready  = (r_count != CNT_W'(FIFO_DEPTH)) || w_pop;
        w_push      = i_wr_valid && o_wr_ready;
        o_bus_req   = (r_state == REQ) || (r_state == XFER);
        o_bus_ack   = (r_state == REL);
        o_bus_valid = w_bus_valid;
        o_err       = r_err;
        if (w_bus_valid) begin
            o_bus_data = r_mem[r_rd_ptr];
        end else begin
            o_bus_data = {DATA_W{1'b0}};
        end
    end

    // Burst length latched at grant: whatever is queued, capped at MAX_BURST.
    // Words pushed later are not part of this tenure.
    always_comb begin
        if (r_count > CNT_W'(MAX_BURST)) begin
            w_burst_len = BEAT_W'(MAX_BURST);
        end else begin
            w_burst_len = BEAT_W'(r_count);
        end
    end

    // Next-state logic for the request/transfer/release sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != {CNT_W{1'b0}}) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (i_bus_grant) begin
                    w_state_nxt = XFER;
                    w_beats_nxt = w_burst_len;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            XFER: begin
                if (!i_bus_grant) begin
                    // Protocol violation: abandon the tenure without an ack.
                    w_state_nxt = IDLE;
                    w_err_set   = 1'b1;
                end else if (!i_bus_wait) begin
                    w_beats_nxt = r_beats - BEAT_W'(1);
                    if (r_beats == BEAT_W'(1)) begin
                        w_state_nxt = REL;
                    end else begin
                        w_state_nxt = XFER;
                    end
                end else begin
                    w_state_nxt = XFER;
                end
            end
            REL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, beat counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beats <= {BEAT_W{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; reset discards any queued words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

    logic       clk;
    logic       reset;
    logic       i_wr_valid;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic       i_bus_grant;
    logic       i_bus_wait;
    logic       o_bus_req;
    logic       o_bus_ack;
    logic       o_bus_valid;
    logic [7:0] o_bus_data;
    logic       o_err;

    int total;
    int bad;

    bus_master_port #(
        .DATA_W(8),
        .FIFO_DEPTH(8),
        .MAX_BURST(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .i_bus_grant(i_bus_grant),
        .i_bus_wait (i_bus_wait),
        .o_bus_req  (o_bus_req),
        .o_bus_ack  (o_bus_ack),
        .o_bus_valid(o_bus_valid),
        .o_bus_data (o_bus_data),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered with the port in REQ: grant, expect n consecutive words starting
    // at d0, then a single ack cycle with req low, then idle.
    task automatic do_burst(input int n, input logic [7:0] d0);
        logic [7:0] exp_d;
        i_bus_grant = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            exp_d = d0 + 8'(i);
            chk1("burst_valid", o_bus_valid, 1'b1);
            chk8("burst_data", o_bus_data, exp_d);
            chk1("burst_req", o_bus_req, 1'b1);
            chk1("burst_noack", o_bus_ack, 1'b0);
            tick();
        end
        chk1("rel_ack", o_bus_ack, 1'b1);
        chk1("rel_req", o_bus_req, 1'b0);
        chk1("rel_valid", o_bus_valid, 1'b0);
        chk8("rel_data", o_bus_data, 8'h00);
        i_bus_grant = 1'b0;
        tick();
        chk1("idle_ack", o_bus_ack, 1'b0);
        chk1("idle_req", o_bus_req, 1'b0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        i_wr_valid  = 1'b0;
        i_wr_data   = 8'h00;
        i_bus_grant = 1'b0;
        i_bus_wait  = 1'b0;
        #2;
        chk1("rst_req", o_bus_req, 1'b0);
        chk1("rst_ack", o_bus_ack, 1'b0);
        chk1("rst_valid", o_bus_valid, 1'b0);
        chk8("rst_data", o_bus_data, 8'h00);
        chk1("rst_err", o_err, 1'b0);
        chk1("rst_wr_ready", o_wr_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();

        // Single word
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hA5;
        tick();
        i_wr_valid = 1'b0;
        chk1("t1_req_write_edge", o_bus_req, 1'b0);
        tick();
        chk1("t1_req_next_edge", o_bus_req, 1'b1);
        chk1("t1_valid_before_grant", o_bus_valid, 1'b0);
        do_burst(1, 8'hA5);
        chk1("t1_wr_ready", o_wr_ready, 1'b1);
        tick();
        chk1("t1_stays_idle", o_bus_req, 1'b0);

        // Burst split: 6 words, two tenures of 4 and 2
        for (int i = 0; i < 6; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(i + 1);
            tick();
        end
        i_wr_valid = 1'b0;
        chk1("t2_req", o_bus_req, 1'b1);
        do_burst(4, 8'h01);
        tick();
        chk1("t2_rereq", o_bus_req, 1'b1);
        do_burst(2, 8'h05);

        // Full and pointer wrap
        for (int i = 0; i < 8; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h10 + 8'(i);
            tick();
        end
        i_wr_data = 8'h18;
        chk1("t3_full_wr_ready", o_wr_ready, 1'b0);
        tick();
        i_wr_valid  = 1'b0;
        chk1("t3_req", o_bus_req, 1'b1);
        i_bus_grant = 1'b1;
        tick();
        chk8("t3_beat0", o_bus_data, 8'h10);
        for (int i = 0; i < 4; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h20 + 8'(i);
            chk1("t3_wr_ready_pop", o_wr_ready, 1'b1);
            tick();
            if (i < 3) begin
                chk8("t3_beat", o_bus_data, 8'h11 + 8'(i));
            end else begin
                chk1("t3_ack", o_bus_ack, 1'b1);
            end
        end
        i_wr_valid  = 1'b0;
        i_bus_grant = 1'b0;
        tick();
        tick();
        chk1("t3_req2", o_bus_req, 1'b1);
        do_burst(4, 8'h14);
        tick();
        chk1("t3_req3", o_bus_req, 1'b1);
        do_burst(4, 8'h20);
        tick();
        chk1("t3_empty_no_req", o_bus_req, 1'b0);

        // Stall on beat 2 of a 3-beat burst
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h31 + 8'(i);
            tick();
        end
        i_wr_valid  = 1'b0;
        i_bus_grant = 1'b1;
        tick();
        chk8("t4_beat1", o_bus_data, 8'h31);
        tick();
        i_bus_wait = 1'b1;
        chk8("t4_beat2_c1", o_bus_data, 8'h32);
        tick();
        chk8("t4_beat2_c2", o_bus_data, 8'h32);
        chk1("t4_valid_c2", o_bus_valid, 1'b1);
        tick();
        chk8("t4_beat2_c3", o_bus_data, 8'h32);
        i_bus_wait = 1'b0;
        tick();
        chk8("t4_beat3", o_bus_data, 8'h33);
        chk1("t4_no_early_ack", o_bus_ack, 1'b0);
        tick();
        chk1("t4_ack", o_bus_ack, 1'b1);
        chk1("t4_valid_end", o_bus_valid, 1'b0);
        i_bus_grant = 1'b0;
        tick();

        // Grant loss in the 2nd transfer cycle of a 4-beat burst
        for (int i = 0; i < 4; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h41 + 8'(i);
            tick();
        end
        i_wr_valid  = 1'b0;
        i_bus_grant = 1'b1;
        tick();
        chk8("t5_beat1", o_bus_data, 8'h41);
        tick();
        chk8("t5_beat2", o_bus_data, 8'h42);
        i_bus_grant = 1'b0;
        tick();
        chk1("t5_err", o_err, 1'b1);
        chk1("t5_no_ack", o_bus_ack, 1'b0);
        chk1("t5_valid_off", o_bus_valid, 1'b0);
        chk1("t5_req_off", o_bus_req, 1'b0);
        tick();
        chk1("t5_rereq", o_bus_req, 1'b1);
        chk1("t5_no_ack2", o_bus_ack, 1'b0);
        do_burst(3, 8'h42);
        chk1("t5_err_sticky", o_err, 1'b1);

        // Reset during beat 2
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h51 + 8'(i);
            tick();
        end
        i_wr_valid  = 1'b0;
        i_bus_grant = 1'b1;
        tick();
        tick();
        chk8("t6_beat2", o_bus_data, 8'h52);
        #2;
        reset       = 1'b1;
        i_bus_grant = 1'b0;
        #1;
        chk1("t6_valid", o_bus_valid, 1'b0);
        chk1("t6_req", o_bus_req, 1'b0);
        chk1("t6_ack", o_bus_ack, 1'b0);
        chk8("t6_data", o_bus_data, 8'h00);
        chk1("t6_err_cleared", o_err, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        chk1("t6_wr_ready", o_wr_ready, 1'b1);
        chk1("t6_no_req", o_bus_req, 1'b0);
        tick();
        chk1("t6_no_req2", o_bus_req, 1'b0);
        chk1("t6_no_ack", o_bus_ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
